// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop,
// operands consumed LSB first, one bit per clock, start/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_am;
  logic             r_bm;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_bit;
  logic             w_cout;
  logic [WIDTH:0]   w_cat;
  logic [WIDTH-1:0] w_sum_next;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = start && !w_run;
  assign w_last   = w_run && (r_cnt == LAST);

  assign w_bit  = r_sa[0] ^ r_sb[0] ^ r_carry;
  assign w_cout = (r_sa[0] & r_sb[0])
                | (r_sa[0] & r_carry)
                | (r_sb[0] & r_carry);

  // New bit enters at the MSB; after WIDTH steps the LSB lands at bit 0.
  assign w_cat      = {w_bit, r_sum};
  assign w_sum_next = w_cat[WIDTH:1];

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_am    <= 1'b0;
      r_bm    <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_sa    <= a;
      r_sb    <= op ? ~b : b;
      r_carry <= op ? 1'b1 : ci;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_am    <= a[WIDTH-1];
      r_bm    <= op ? ~b[WIDTH-1] : b[WIDTH-1];
    end else if (w_run) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_carry <= w_cout;
      r_sum   <= w_sum_next;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_s   <= w_sum_next;
        r_co  <= w_cout;
        r_ovf <= (r_am == r_bm)
              && (w_sum_next[WIDTH-1] != r_am);
      end
    end
  end

  assign busy = w_run;
  assign done = (r_state == S_DONE);
  assign s    = r_s;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized check of serial_adder (WIDTH=8 and WIDTH=1)
// against an integer-arithmetic reference model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       st, op, ci;
  logic [7:0] a, b;
  logic       busy, done, co, ovf;
  logic [7:0] s;

  logic       st1, op1, a1, b1, ci1;
  logic       busy1, done1, s1, co1, ovf1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] prev_s;
  logic       prev_co, prev_ovf;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clock(clk), .reset(rst), .start(st), .op(op),
    .a(a), .b(b), .ci(ci), .busy(busy), .done(done),
    .s(s), .co(co), .ovf(ovf)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clock(clk), .reset(rst), .start(st1), .op(op1),
    .a(a1), .b(b1), .ci(ci1), .busy(busy1), .done(done1),
    .s(s1), .co(co1), .ovf(ovf1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model8(
    input  logic       o,
    input  logic [7:0] x, y,
    input  logic       c,
    output logic [7:0] es,
    output logic       eco, eov);
    int ux, uy, sx, sy, full, sres;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (o) begin
      full = ux - uy + 256;
      sres = sx - sy;
    end else begin
      full = ux + uy + int'(c);
      sres = sx + sy + int'(c);
    end
    es  = 8'(full % 256);
    eco = (full >= 256);
    eov = (sres > 127) || (sres < -128);
  endfunction

  // Caller is one step past an edge with the DUT in IDLE or DONE.
  task automatic run_op(input logic o,
                        input logic [7:0] x, y,
                        input logic c,
                        input bit inject);
    logic [7:0] es;
    logic eco, eov;
    int lat;
    model8(o, x, y, c, es, eco, eov);
    op = o; a = x; b = y; ci = c; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    op = 1'($urandom); ci = 1'($urandom);
    a = 8'($urandom); b = 8'($urandom);
    check("busy_run", busy, 1);
    check("hold_s", s, prev_s);
    check("hold_co", co, prev_co);
    lat = 0;
    while (!done && lat < 20) begin
      st = (inject && lat == 3);
      @(posedge clk); #1;
      lat++;
    end
    st = 1'b0;
    check("latency", lat, 8);
    check("s", s, es);
    check("co", co, eco);
    check("ovf", ovf, eov);
    check("busy_done", busy, 0);
    prev_s = es; prev_co = eco; prev_ovf = eov;
  endtask

  initial begin
    int seen;
    logic [1:0] fa;
    int sres;
    rst = 1'b1; st = 0; op = 0; a = 0; b = 0; ci = 0;
    st1 = 0; op1 = 0; a1 = 0; b1 = 0; ci1 = 0;
    prev_s = 0; prev_co = 0; prev_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_co", co, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy1", busy1, 0);
    rst = 1'b0;

    run_op(0, 8'h3C, 8'h5A, 0, 0);
    run_op(0, 8'hFF, 8'h01, 0, 0);
    run_op(0, 8'hFF, 8'h00, 1, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    run_op(1, 8'h05, 8'h07, 0, 0);
    run_op(1, 8'h80, 8'h01, 0, 0);

    // mid-run start ignored, then back-to-back accept in DONE
    run_op(0, 8'h12, 8'h34, 1, 1);
    run_op(1, 8'h40, 8'hC0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        check("done_pulse", done, 0);
      end
    end

    // reset three clocks into RUN
    op = 0; a = 8'hAA; b = 8'h55; ci = 1; st = 1;
    @(posedge clk); #1;
    st = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_s", s, 0);
    check("abort_co", co, 0);
    check("abort_ovf", ovf, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_nodone", seen, 0);
    prev_s = 0; prev_co = 0; prev_ovf = 0;
    run_op(0, 8'h7F, 8'h01, 0, 0);

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; ci1 = i[0]; op1 = 0; st1 = 1;
      fa = 2'(i[2] + i[1] + i[0]);
      sres = -int'(i[2]) - int'(i[1]) + int'(i[0]);
      @(posedge clk); #1;
      st1 = 0;
      check("w1_busy", busy1, 1);
      @(posedge clk); #1;
      check("w1_done", done1, 1);
      check("w1_idle", busy1, 0);
      check("w1_sum", {co1, s1}, fa);
      check("w1_ovf", ovf1, (sres > 0) || (sres < -1));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
